// File: rtl/bus_ctrl_pkg.sv
// Shared types for the 8008 bus controller: core state encoding and bus cycle types.
package internal_defines;

  typedef enum logic [2:0] {
    WAIT    = 3'b000,
    T2      = 3'b001,
    T1      = 3'b010,
    T1I     = 3'b011,
    T3      = 3'b100,
    T5      = 3'b101,
    STOPPED = 3'b110,
    T4      = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    PCI = 2'b00,
    PCR = 2'b01,
    PCC = 2'b10,
    PCW = 2'b11
  } cycle_type_t;

endpackage

// File: rtl/bus_ctrl_wait_gen.sv
// Wait-state generator: loadable down-counter saturating at zero, with a
// registered ready flag that is high whenever the count is zero.
module wait_gen #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 ready
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (load)
      cnt_next = load_val;
    else if (dec && (cnt != '0))
      cnt_next = cnt - 1'b1;
  end

  // ready mirrors the next count so it is a flop output, never combinational
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      ready <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// 8008 processor-side bus controller: demultiplexes address/cycle type from
// T1/T2, runs the memory or I/O transfer in T3 and paces the core via ready.
module bus_ctrl
  import internal_defines::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  state_t                state,
  input  logic [DATA_WIDTH-1:0] core_dout,
  output logic [DATA_WIDTH-1:0] core_din,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rd,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output cycle_type_t           cycle_type,
  output logic [4:0]            io_port,
  input  logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  io_rd,
  output logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_wr,
  input  logic [DATA_WIDTH-1:0] intr_opcode,
  output logic                  intr_ack
);

  localparam int HI_W = ADDR_WIDTH - DATA_WIDTH;

  logic [DATA_WIDTH-1:0] addr_lo;
  logic [HI_W-1:0]       addr_hi;
  logic                  ack_q;
  logic                  in_t1;
  logic                  is_inp;

  assign in_t1    = (state == T1) || (state == T1I);
  assign mem_addr = {addr_hi, addr_lo};
  assign io_port  = addr_hi[HI_W-1:1];
  assign io_wdata = addr_lo;
  assign is_inp   = (io_port[4:3] == 2'b00);

  wait_gen #(
    .CNT_WIDTH (4)
  ) u_wait_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (in_t1),
    .dec      ((state == T2) || (state == WAIT)),
    .load_val (4'(WAIT_STATES)),
    .ready    (ready)
  );

  always_comb begin
    core_din = '0;
    mem_rd   = 1'b0;
    io_rd    = 1'b0;
    intr_ack = 1'b0;
    if (state == T3) begin
      case (cycle_type)
        PCI: begin
          // interrupt-acknowledge fetch: jam the opcode instead of reading memory
          if (ack_q) begin
            core_din = intr_opcode;
            intr_ack = 1'b1;
          end else begin
            core_din = mem_rdata;
            mem_rd   = 1'b1;
          end
        end
        PCR: begin
          core_din = mem_rdata;
          mem_rd   = 1'b1;
        end
        PCC: begin
          if (is_inp) begin
            core_din = io_rdata;
            io_rd    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo    <= '0;
      addr_hi    <= '0;
      ack_q      <= 1'b0;
      cycle_type <= PCI;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      io_wr      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      io_wr  <= 1'b0;
      if (in_t1) begin
        addr_lo <= core_dout;
        ack_q   <= (state == T1I);
      end
      if (state == T2) begin
        addr_hi    <= core_dout[HI_W-1:0];
        cycle_type <= cycle_type_t'(core_dout[DATA_WIDTH-1 -: 2]);
      end
      // write strobes fire in the clk after T3, with address and data still held
      if (state == T3) begin
        if (cycle_type == PCW) begin
          mem_wdata <= core_dout;
          mem_we    <= 1'b1;
        end
        if ((cycle_type == PCC) && !is_inp)
          io_wr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: two instances (0 and 3 wait states) driven by a simple
// core model, checked against transaction-level expectations.
module tb_bus_ctrl;
  import internal_defines::*;

  logic        clk;
  logic        rst;
  state_t      st [2];
  logic [7:0]  core_dout;
  logic [7:0]  io_rdata;
  logic [7:0]  intr_opcode;

  logic [7:0]  core_din  [2];
  logic        ready     [2];
  logic [13:0] mem_addr  [2];
  logic [7:0]  mem_rdata [2];
  logic        mem_rd    [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_we    [2];
  cycle_type_t ctype     [2];
  logic [4:0]  io_port   [2];
  logic        io_rd     [2];
  logic [7:0]  io_wdata  [2];
  logic        io_wr     [2];
  logic        intr_ack  [2];

  logic [7:0]  mem [16384];
  logic        t1_pre [2];

  int n_cmp = 0;
  int n_err = 0;

  assign mem_rdata[0] = mem[mem_addr[0]];
  assign mem_rdata[1] = mem[mem_addr[1]];

  bus_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .state(st[0]), .core_dout(core_dout), .core_din(core_din[0]),
    .ready(ready[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .mem_rd(mem_rd[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .cycle_type(ctype[0]), .io_port(io_port[0]),
    .io_rdata(io_rdata), .io_rd(io_rd[0]), .io_wdata(io_wdata[0]), .io_wr(io_wr[0]),
    .intr_opcode(intr_opcode), .intr_ack(intr_ack[0])
  );

  bus_ctrl #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .state(st[1]), .core_dout(core_dout), .core_din(core_din[1]),
    .ready(ready[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .mem_rd(mem_rd[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .cycle_type(ctype[1]), .io_port(io_port[1]),
    .io_rdata(io_rdata), .io_rd(io_rd[1]), .io_wdata(io_wdata[1]), .io_wr(io_wr[1]),
    .intr_opcode(intr_opcode), .intr_ack(intr_ack[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic drive(int d, state_t s, logic [7:0] dout);
    @(negedge clk);
    st[d]     = s;
    core_dout = dout;
    #1;
  endtask

  task automatic check_reset_vals(int d);
    chk($sformatf("rst_ready%0d", d),    16'(ready[d]),     16'h1);
    chk($sformatf("rst_addr%0d", d),     16'(mem_addr[d]),  16'h0);
    chk($sformatf("rst_wdata%0d", d),    16'(mem_wdata[d]), 16'h0);
    chk($sformatf("rst_iowdata%0d", d),  16'(io_wdata[d]),  16'h0);
    chk($sformatf("rst_ctype%0d", d),    16'(ctype[d]),     16'(PCI));
    chk($sformatf("rst_din%0d", d),      16'(core_din[d]),  16'h0);
    chk($sformatf("rst_strobes%0d", d),
        16'({mem_rd[d], mem_we[d], io_rd[d], io_wr[d], intr_ack[d]}), 16'h0);
  endtask

  // One complete bus transfer as seen from the core. With chain set, the clk
  // after T3 is the next transfer's T1 carrying next_lo.
  task automatic xact(int d, logic t1i, cycle_type_t ct, logic [13:0] addr,
                      logic [7:0] wd, logic chain, logic [7:0] next_lo, logic extra);
    int         ws;
    int         waits;
    logic       is_in;
    logic       is_out;
    logic       exp_rd;
    logic [7:0] exp_din;
    ws = (d == 0) ? 0 : 3;
    if (!t1_pre[d]) drive(d, t1i ? T1I : T1, addr[7:0]);
    t1_pre[d] = 1'b0;
    drive(d, T2, {ct, addr[13:8]});
    chk("t2_ready", 16'(ready[d]), 16'(ws == 0));
    waits = 0;
    while (!ready[d] && waits < 40) begin
      drive(d, WAIT, 8'($urandom));
      waits++;
    end
    chk("wait_count", 16'(waits), 16'(ws));
    if (extra && ws != 0) begin
      drive(d, WAIT, 8'($urandom));
      chk("wait_saturate", 16'(ready[d]), 16'h1);
    end
    drive(d, T3, wd);
    is_in  = (ct == PCC) && (addr[13:12] == 2'b00);
    is_out = (ct == PCC) && (addr[13:12] != 2'b00);
    exp_rd = ((ct == PCI) && !t1i) || (ct == PCR);
    case (ct)
      PCI:     exp_din = t1i ? intr_opcode : mem[addr];
      PCR:     exp_din = mem[addr];
      PCC:     exp_din = is_in ? io_rdata : 8'h00;
      default: exp_din = 8'h00;
    endcase
    chk("t3_addr",     16'(mem_addr[d]), 16'(addr));
    chk("t3_ctype",    16'(ctype[d]),    16'(ct));
    chk("t3_ioport",   16'(io_port[d]),  16'(addr[13:9]));
    chk("t3_din",      16'(core_din[d]), 16'(exp_din));
    chk("t3_memrd",    16'(mem_rd[d]),   16'(exp_rd));
    chk("t3_intrack",  16'(intr_ack[d]), 16'((ct == PCI) && t1i));
    chk("t3_iord",     16'(io_rd[d]),    16'(is_in));
    chk("t3_wstrobes", 16'({mem_we[d], io_wr[d]}), 16'h0);
    chk("t3_ready",    16'(ready[d]),    16'h1);
    if (chain) drive(d, T1, next_lo);
    else       drive(d, T4, 8'($urandom));
    chk("post_memwe",  16'(mem_we[d]),   16'(ct == PCW));
    chk("post_iowr",   16'(io_wr[d]),    16'(is_out));
    chk("post_addr",   16'(mem_addr[d]), 16'(addr));
    chk("post_din",    16'(core_din[d]), 16'h0);
    chk("post_rd",     16'({mem_rd[d], io_rd[d], intr_ack[d]}), 16'h0);
    if (ct == PCW) chk("post_wdata", 16'(mem_wdata[d]), 16'(wd));
    if (is_out) begin
      chk("post_iowdata", 16'(io_wdata[d]), 16'(addr[7:0]));
      chk("post_ioport",  16'(io_port[d]),  16'(addr[13:9]));
    end
    if (chain) t1_pre[d] = 1'b1;
    else begin
      drive(d, T5, 8'($urandom));
      chk("pulse_width", 16'({mem_we[d], io_wr[d]}), 16'h0);
      drive(d, STOPPED, 8'h00);
    end
  endtask

  initial begin
    cycle_type_t ct_c, ct_n;
    logic [13:0] ad_c, ad_n;
    logic        i1_c, i1_n;
    logic        chain;
    int          waits;

    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    st[0] = STOPPED;
    st[1] = STOPPED;
    core_dout = 8'h00;
    io_rdata = 8'h00;
    intr_opcode = 8'h00;
    t1_pre[0] = 1'b0;
    t1_pre[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);

    // zero wait states: PCR read from 0x1234
    mem[14'h1234] = 8'hA5;
    xact(0, 1'b0, PCR, 14'h1234, 8'h00, 1'b0, 8'h00, 1'b0);

    // three wait states: PCI fetch, then write to top of memory
    xact(1, 1'b0, PCI, 14'h0456, 8'h00, 1'b0, 8'h00, 1'b1);
    xact(1, 1'b0, PCW, 14'h3FFF, 8'h5A, 1'b0, 8'h00, 1'b0);

    // interrupt acknowledge followed by an ordinary fetch
    intr_opcode = 8'h05;
    xact(1, 1'b1, PCI, 14'h0100, 8'h00, 1'b0, 8'h00, 1'b0);
    xact(1, 1'b0, PCI, 14'h0100, 8'h00, 1'b0, 8'h00, 1'b0);

    // INP port 1, then OUT port 8 with A=0x3C
    io_rdata = 8'h77;
    xact(1, 1'b0, PCC, 14'h0211, 8'h00, 1'b0, 8'h00, 1'b0);
    xact(0, 1'b0, PCC, 14'h103C, 8'h00, 1'b0, 8'h00, 1'b0);

    // write pulse landing in the following T1
    xact(0, 1'b0, PCW, 14'h2A55, 8'hC7, 1'b1, 8'h99, 1'b0);
    xact(0, 1'b0, PCR, 14'h0A99, 8'h00, 1'b0, 8'h00, 1'b0);

    // randomized transfers on both instances
    for (int d = 0; d < 2; d++) begin
      ct_c = cycle_type_t'($urandom_range(0, 3));
      ad_c = 14'($urandom);
      i1_c = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < 25; n++) begin
        chain = $urandom_range(0, 1) == 1;
        ct_n  = cycle_type_t'($urandom_range(0, 3));
        ad_n  = 14'($urandom);
        i1_n  = chain ? 1'b0 : ($urandom_range(0, 3) == 0);
        io_rdata    = 8'($urandom);
        intr_opcode = 8'($urandom);
        xact(d, i1_c, ct_c, ad_c, 8'($urandom), chain, ad_n[7:0], $urandom_range(0, 1) == 1);
        ct_c = ct_n;
        ad_c = ad_n;
        i1_c = i1_n;
      end
      if (t1_pre[d]) xact(d, 1'b0, ct_c, ad_c, 8'h00, 1'b0, 8'h00, 1'b0);
    end

    // reset during the T3 of a PCW on the wait-state instance
    drive(1, T1I, 8'h11);
    drive(1, T2, {PCW, 6'h05});
    waits = 0;
    while (!ready[1] && waits < 40) begin
      drive(1, WAIT, 8'h00);
      waits++;
    end
    chk("rst_pcw_waits", 16'(waits), 16'd3);
    drive(1, T3, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st[1] = T4;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    drive(1, T5, 8'h00);
    chk("rst_no_late_we", 16'(mem_we[1]), 16'h0);
    xact(1, 1'b0, PCI, 14'h0033, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Processor-side bus controller sitting directly downstream of the 8008 core: it watches the core's per-clock state output and multiplexed data bus, demultiplexes the 14-bit address and 2-bit cycle type sent during T1/T2, and runs the memory/I-O transfer in T3. It generates the core's `Ready` input, with a programmable wait-state count, and drives the core's `D_in`, jamming an interrupt opcode during interrupt-acknowledge fetches.

## Interface
- `WAIT_STATES`, 0 — WAIT states inserted per transfer (0..15).
- `DATA_WIDTH`, 8 — core data bus width.
- `ADDR_WIDTH`, 14 — memory address width.

- `clk`  in  1  — clock; the core advances one state per `clk`.
- `rst`  in  1  — reset, synchronous, active-high.
- `state`  in  state_t  — core state (T1, T1I, T2, WAIT, T3, STOPPED, T4, T5).
- `core_dout`  in  8  — core `D_out`.
- `core_din`  out  8  — core `D_in`.
- `ready`  out  1  — core `Ready`.
- `mem_addr`  out  14  — memory address; `mem_rdata` is combinational from it.
- `mem_rdata`  in  8  — memory read data.
- `mem_rd`  out  1  — memory read strobe.
- `mem_wdata`  out  8  — memory write data.
- `mem_we`  out  1  — memory write-enable pulse.
- `cycle_type`  out  cycle_type_t  — latched cycle type.
- `io_port`  out  5  — I/O port number.
- `io_rdata`  in  8  — input-port data.
- `io_rd`  out  1  — input strobe.
- `io_wdata`  out  8  — output-port data.
- `io_wr`  out  1  — output-port write pulse.
- `intr_opcode`  in  8  — instruction jammed on interrupt acknowledge.
- `intr_ack`  out  1  — interrupt-acknowledge fetch in progress.

## Operation
- Clock edge with `state`==T1 or T1I: `addr_lo`<=`core_dout`; `ack_q`<=(`state`==T1I); `wait_cnt`<=`WAIT_STATES`.
- Clock edge with `state`==T2: `addr_hi`<=`core_dout[5:0]`; `cycle_type`<=`core_dout[7:6]` (00 PCI, 01 PCR, 10 PCC, 11 PCW).
- Clock edge with `state` in {T2, WAIT} and `wait_cnt`!=0: decrement `wait_cnt`.
- `ready` = (`wait_cnt`==0), taken from the register only. A transfer therefore has exactly `WAIT_STATES` WAIT states.
- `mem_addr` = {`addr_hi`,`addr_lo`}. It holds until the next T1/T1I edge.
- `io_port` = `addr_hi[5:1]`.
- `io_wdata` = `addr_lo`, the accumulator sent in T1 of a PCC cycle.
- During T3, the cycle type selects the action:
  - PCI or PCR: `mem_rd`=1 and `core_din`=`mem_rdata`.
  - PCI with `ack_q`: `core_din`=`intr_opcode`, `intr_ack`=1, `mem_rd`=0.
  - PCC with `io_port[4:3]`==00 (INP): `io_rd`=1 and `core_din`=`io_rdata`.
  - PCC with any other port (OUT): capture for a write on the next cycle.
  - PCW: capture `mem_wdata`<=`core_dout` at the T3 edge.
- Outside T3, `core_din`=0x00 and all strobes are 0.
- Clock after T3:
  - PCW: `mem_we`=1 for exactly one clk.
  - OUT: `io_wr`=1 for exactly one clk.
- STOPPED, T4, T5: no bus activity. Latched values are held.

## Timing
- Reset values: `ready`=1, `mem_addr`=0, `mem_wdata`=0, `io_wdata`=0, `cycle_type`=PCI, `core_din`=0.
- All strobes are 0 at reset, and `ack_q`=0.
- Reset mid-transfer clears `wait_cnt`, `ack_q` and any pending `mem_we`/`io_wr` pulse in the same cycle.
- Latency:
  - Address valid from the first clk after T2.
  - Read data is combinational in T3.
  - Write strobe falls in the clk after T3; `mem_addr` and `mem_wdata` stay stable through it.
- T3 followed directly by T1: the write pulse coincides with T1. The address updates only at the end of that T1, so the write still uses the old address.
- `WAIT_STATES`=0: `ready` stays 1 throughout and the core goes T2→T3.
- WAIT with `ready`=0 is extended indefinitely only if `wait_cnt` is nonzero. `wait_cnt` never underflows; it saturates at 0.

## Structure
- Shared package `internal_defines` holds `state_t` and `cycle_type_t` (PCI/PCR/PCC/PCW).
- Sub-module `wait_gen`: loadable down-counter, saturating at 0, with the registered `ready` flag.

## Test plan
- `WAIT_STATES`=0; T1 `core_dout`=0x34, T2 `core_dout`=0x52 (PCR, hi=0x12), T3 with `mem_rdata`=0xA5 → `mem_addr`=0x1234, `mem_rd`=1, `core_din`=0xA5 in T3, `ready` stays 1.
- `WAIT_STATES`=3; PCI fetch with the core holding WAIT while `ready`=0 → exactly 3 WAIT states, `ready` rises on the 3rd, T3 follows.
- PCW: T1 0xFF, T2 0xFF, T3 `core_dout`=0x5A → `mem_we`=1 for one clk after T3 with `mem_addr`=0x3FFF, `mem_wdata`=0x5A.
- T1I then PCI fetch, `intr_opcode`=0x05 → `core_din`=0x05, `intr_ack`=1, `mem_rd`=0 in T3; the next T1 fetch clears `ack_q`.
- PCC: T2 `core_dout`=0x82 (port 1) with `io_rdata`=0x77 → `io_rd` and `core_din`=0x77 in T3. Then T2 0x90 (port 8), T1 A=0x3C → `io_wr` pulse with `io_port`=8, `io_wdata`=0x3C.
- `rst` asserted in the T3 of a PCW → no `mem_we` pulse; all outputs return to reset values next clk.
